// File: rtl/pingpong_counter_param.sv
// Parameterised ping-pong counter with programmable step, four counting
// modes, synchronous clamped load, latched flip request and status flags.
// Advances only on a one-cycle tick strobe; everything runs on clk_i.
module pingpong_counter_param #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              enable_i,
    input  logic              flip_i,
    input  logic [1:0]        mode_i,
    input  logic [WIDTH-1:0]  max_i,
    input  logic [WIDTH-1:0]  min_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              direction_o,
    output logic              at_max_o,
    output logic              at_min_o,
    output logic              bounce_o,
    output logic              cfg_err_o
);

    localparam logic [1:0] MODE_PP   = 2'd0;
    localparam logic [1:0] MODE_WUP  = 2'd1;
    localparam logic [1:0] MODE_WDN  = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             pend_q, pend_d;
    logic             bounce_q, bounce_d;

    logic [WIDTH-1:0] step_w;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   down_floor;
    logic [WIDTH-1:0] up_sat;
    logic [WIDTH-1:0] down_sat;
    logic [WIDTH-1:0] load_clamped;
    logic             bounds_ok;
    logic             load_ok;
    logic             advance;
    logic             pp_dir;

    // A zero step counts as one; the step is widened so the up-sum and the
    // down-floor compare can never overflow into a visible wrap.
    assign step_w     = (step_i == '0) ? WIDTH'(1) : WIDTH'(step_i);
    assign step_x     = {1'b0, step_w};
    assign up_sum     = {1'b0, count_q} + step_x;
    assign down_floor = {1'b0, min_i} + step_x;

    // Saturating moves for ping-pong; the down subtraction only happens when
    // count >= min + step, so it cannot underflow in WIDTH bits.
    assign up_sat   = (up_sum > {1'b0, max_i}) ? max_i : up_sum[WIDTH-1:0];
    assign down_sat = ({1'b0, count_q} < down_floor) ? min_i : (count_q - step_w);

    assign load_clamped = (load_val_i > max_i) ? max_i :
                          (load_val_i < min_i) ? min_i : load_val_i;

    assign at_max_o    = (count_q == max_i);
    assign at_min_o    = (count_q == min_i);
    assign bounds_ok   = (min_i < max_i);
    assign cfg_err_o   = !bounds_ok || (count_q < min_i) || (count_q > max_i);
    assign load_ok     = load_i && bounds_ok;
    assign advance     = tick_i && enable_i && !cfg_err_o && (mode_i != MODE_HOLD);

    // Ping-pong direction: requested flip first, then the endpoints override it.
    always_comb begin
        pp_dir = dir_q ^ (pend_q | flip_i);
        if (at_max_o) begin
            pp_dir = 1'b0;
        end else if (at_min_o) begin
            pp_dir = 1'b1;
        end
    end

    // Next-state selection: load beats advance beats idle.
    always_comb begin
        count_d  = count_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        bounce_d = 1'b0;
        if (load_ok) begin
            count_d = load_clamped;
            pend_d  = 1'b0;
        end else if (advance) begin
            case (mode_i)
                MODE_PP: begin
                    count_d  = pp_dir ? up_sat : down_sat;
                    dir_d    = pp_dir;
                    pend_d   = 1'b0;
                    bounce_d = (at_max_o || at_min_o) && (pp_dir != dir_q);
                end
                MODE_WUP: begin
                    if (up_sum > {1'b0, max_i}) begin
                        count_d  = min_i;
                        bounce_d = 1'b1;
                    end else begin
                        count_d = up_sum[WIDTH-1:0];
                    end
                    dir_d  = 1'b1;
                    pend_d = pend_q | flip_i;
                end
                MODE_WDN: begin
                    if ({1'b0, count_q} < down_floor) begin
                        count_d  = max_i;
                        bounce_d = 1'b1;
                    end else begin
                        count_d = count_q - step_w;
                    end
                    dir_d  = 1'b0;
                    pend_d = pend_q | flip_i;
                end
                default: begin
                    pend_d = pend_q | flip_i;
                end
            endcase
        end else if (flip_i) begin
            pend_d = 1'b1;
        end
    end

    // State registers with synchronous reset to the current lower bound.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= min_i;
            dir_q    <= 1'b1;
            pend_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            bounce_q <= bounce_d;
        end
    end

    assign count_o     = count_q;
    assign direction_o = dir_q;
    assign bounce_o    = bounce_q;

endmodule

// File: doc/pingpong_counter_param.md
Name: pingpong_counter_param

Overview:
- Generalised ping-pong counter. Counter width and step width are parameters.
- Adds a programmable step, four counting modes, a synchronous load, a latched flip request and status flags.
- Sits between the debounce/onepulse front-end and the seven-segment display mux.
- Advances only on a one-cycle `tick` strobe from a clock divider; all logic runs on the single fast `clk`.

Parameters:
- WIDTH, 8, counter, bound and load-value width in bits.
- STEP_W, 4, step input width in bits.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  advance strobe, one clk cycle wide.
- enable  in  1  1 = counting allowed on tick.
- flip  in  1  one-cycle pulse requesting a direction reversal.
- mode  in  2  0 = ping-pong, 1 = wrap-up, 2 = wrap-down, 3 = hold.
- max  in  WIDTH  upper bound, unsigned.
- min  in  WIDTH  lower bound, unsigned.
- step  in  STEP_W  increment magnitude; 0 is treated as 1.
- load  in  1  one-cycle load request.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count.
- direction  out  1  1 = up, 0 = down.
- at_max  out  1  combinational, count == max.
- at_min  out  1  combinational, count == min.
- bounce  out  1  registered, one-cycle pulse on endpoint reversal or wrap.
- cfg_err  out  1  combinational, asserted when min >= max or count is outside [min, max].

Behaviour:
- Reset (rst = 1 at a clk edge):
  - count <= min (the value sampled at that edge); direction <= 1; flip_pend <= 0; bounce <= 0.
  - Reset overrides every other input.
- Priority per edge: rst > load > advance > idle.
- Advance condition: tick & enable & !cfg_err & mode != 3.
- bounce defaults to 0 on every edge; it is high only the cycle after an event that sets it.
- Load (load = 1, not in reset):
  - count <= load_val, clamped into [min, max]; direction unchanged.
  - flip_pend cleared; cycles with tick or flip in the same cycle are ignored.
  - If min >= max, load is ignored.
- flip_pend register:
  - Set by a flip pulse in any non-load cycle.
  - Consumed (cleared) by the next advance, and only in mode 0.
  - In modes 1–3, flip_pend is held until mode 0 is entered.
  - A flip arriving in the same cycle as an advance is applied by that advance.
- Effective step s = (step == 0) ? 1 : step. All arithmetic uses WIDTH+1 bits; no overflow wrap is ever visible on count.
- Mode 0, ping-pong:
  - Start with d = direction ^ flip_pend_effective.
  - Endpoint override (beats flip): count == max forces d = 0; count == min forces d = 1.
  - Up move: count <= min(count + s, max). Down move: count <= max(count − s, min).
  - direction <= d.
  - bounce <= 1 when the new direction differs from the old one because of the endpoint override.
- Mode 1, wrap-up:
  - If count + s > max, count <= min and bounce <= 1; otherwise count <= count + s.
  - direction <= 1.
- Mode 2, wrap-down:
  - If count < min + s, count <= max and bounce <= 1; otherwise count <= count − s.
  - direction <= 0.
- Mode 3, hold: count and direction frozen; tick is ignored.
- cfg_err handling: while cfg_err is asserted, no advance occurs; count and direction freeze. Counting resumes automatically once the bounds make count legal again.
- Mid-operation bound change: takes effect on the next advance. Clamping happens only through load or reset, never implicitly.
- Latency:
  - count, direction and bounce update at the clk edge that samples tick; visible the next cycle.
  - at_max, at_min and cfg_err follow count combinationally.

Test Plan:
- Reset and basic ping-pong, WIDTH = 8, min = 2, max = 5, step = 1, mode 0.
  - Stimulus: rst, then 8 ticks.
  - Response: count 2,3,4,5,4,3,2,3,4; bounce pulses after reaching 5 and after reaching 2; direction 1 after reset.
- Step saturation, min = 0, max = 10, step = 4, mode 0, from count 0.
  - Response: 4, 8, 10 (bounce), 6, 2, 0 (bounce), 4.
- Flip handling, count = 3, direction up, min = 0, max = 9.
  - Flip with no tick, then tick → count 2, flip_pend cleared.
  - Flip at count = 9 on a tick → endpoint wins, count 8.
  - Flip applied on the advance that leaves 0 → still counts up.
- Wrap modes, min = 1, max = 6, step = 2.
  - Mode 1 from 1: 3, 5, 1 (bounce).
  - Mode 2 from 6: 4, 2, 6 (bounce).
  - Mode 3: 5 ticks leave count unchanged.
- Load and priority, min = 3, max = 7.
  - load_val = 9 → count 7.
  - load_val = 0 → count 3.
  - load together with tick → load wins.
  - rst together with load → count = min, direction = 1.
- Config error and step 0.
  - Set min = 8, max = 4 → cfg_err = 1; ticks leave count frozen.
  - Restore min = 0, max = 15 → counting resumes.
  - step = 0 → count advances by 1 per tick.
